// File: rtl/fifo_mem_ctrl.sv
// Storage array and wrap-bit pointer controller for the synchronous FIFO.
// Push/pop acceptance, occupancy, registered read port and one-cycle error pulses.
module fifo_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    mem_wr_en,
    input  logic [DATA_WIDTH-1:0]   mem_wr_data,
    input  logic                    mem_rd_en,
    output logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic                    mem_rd_valid,
    output logic                    mem_full,
    output logic                    mem_empty,
    output logic                    mem_wr_err,
    output logic                    mem_rd_err,
    output logic [$clog2(DEPTH):0]  mem_count
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_array [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0]   rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;
    logic                  wr_err_reg;
    logic                  rd_err_reg;

    logic                  full;
    logic                  empty;
    logic                  acc_wr;
    logic                  acc_rd;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign wr_addr = wr_ptr_reg[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_reg[ADDR_WIDTH-1:0];

    // Flags depend only on registered pointers, never on this cycle's requests.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                   (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);

    // A push into a full FIFO is allowed when a pop frees the slot in the same cycle.
    assign acc_rd = mem_rd_en & ~empty;
    assign acc_wr = mem_wr_en & (~full | (mem_rd_en & ~empty));

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (acc_wr) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (acc_rd) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (acc_wr && !acc_rd) begin
            count_next = count_reg + PTR_ONE;
        end else if (acc_rd && !acc_wr) begin
            count_next = count_reg - PTR_ONE;
        end
    end

    // Storage is left unreset so it can map onto block RAM.
    always_ff @(posedge CLK) begin
        if (acc_wr) begin
            mem_array[wr_addr] <= mem_wr_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            wr_err_reg   <= 1'b0;
            rd_err_reg   <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rd_valid_reg <= acc_rd;
            wr_err_reg   <= mem_wr_en & ~acc_wr;
            rd_err_reg   <= mem_rd_en & empty;
            // Non-blocking read returns the old word even if this edge overwrites the slot.
            if (acc_rd) begin
                rd_data_reg <= mem_array[rd_addr];
            end
        end
    end

    assign mem_rd_data  = rd_data_reg;
    assign mem_rd_valid = rd_valid_reg;
    assign mem_full     = full;
    assign mem_empty    = empty;
    assign mem_wr_err   = wr_err_reg;
    assign mem_rd_err   = rd_err_reg;
    assign mem_count    = count_reg;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed self-checking bench for fifo_mem_ctrl: fill, overflow, drain, underflow,
// streaming across wraps, simultaneous push/pop at the boundaries and mid-stream reset.
module tb_fifo_mem_ctrl;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 16;

    logic                  clk;
    logic                  nrst;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  wr_err;
    logic                  rd_err;
    logic [4:0]            count;

    int checks = 0;
    int errors = 0;

    fifo_mem_ctrl #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .CLK         (clk),
        .nRST        (nrst),
        .mem_wr_en   (wr_en),
        .mem_wr_data (wr_data),
        .mem_rd_en   (rd_en),
        .mem_rd_data (rd_data),
        .mem_rd_valid(rd_valid),
        .mem_full    (full),
        .mem_empty   (empty),
        .mem_wr_err  (wr_err),
        .mem_rd_err  (rd_err),
        .mem_count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (nrst) begin
            assert (!$isunknown({wr_en, rd_en}));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; outputs then reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_errs"}, 32'({wr_err, rd_err}), 32'd0);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rdata"}, rd_data, 32'd0);
    endtask

    initial begin
        nrst    = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        step();
        step();
        check_reset_values("reset");
        nrst = 1'b1;
        $display("reset released");

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h100 + 32'(i);
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
            chk("fill_empty", 32'(empty), 32'd0);
            chk("fill_errs", 32'({wr_err, rd_err}), 32'd0);
            $display("push 0x%0h count=%0d", wr_data, count);
        end

        // Overflow push is rejected
        wr_data = 32'hDEAD;
        step();
        chk("ovf_wr_err", 32'(wr_err), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        $display("push 0xdead rejected wr_err=%0d", wr_err);
        wr_en = 1'b0;
        step();
        chk("ovf_err_clear", 32'(wr_err), 32'd0);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            step();
            chk("drain_valid", 32'(rd_valid), 32'd1);
            chk("drain_data", rd_data, 32'h100 + 32'(i));
            chk("drain_rd_err", 32'(rd_err), 32'd0);
            $display("pop 0x%0h count=%0d", rd_data, count);
        end
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
        step();
        chk("udf_rd_err", 32'(rd_err), 32'd1);
        chk("udf_valid", 32'(rd_valid), 32'd0);
        chk("udf_hold", rd_data, 32'h10F);
        $display("pop on empty rd_err=%0d", rd_err);
        rd_en = 1'b0;
        step();
        chk("udf_err_clear", 32'(rd_err), 32'd0);

        // Streaming: 40 pushes, pops start 3 cycles later
        for (int k = 0; k < 43; k++) begin
            wr_en   = (k < 40);
            wr_data = 32'h200 + 32'(k);
            rd_en   = (k >= 3);
            step();
            if (k >= 3) begin
                chk("stream_valid", 32'(rd_valid), 32'd1);
                chk("stream_data", rd_data, 32'h200 + 32'(k - 3));
            end
            chk("stream_count", 32'(count), (k < 3) ? 32'(k + 1) : (k < 40) ? 32'd3 : 32'(42 - k));
            chk("stream_errs", 32'({wr_err, rd_err}), 32'd0);
            $display("stream cycle %0d out=0x%0h count=%0d", k, rd_data, count);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Full plus simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h300 + 32'(i);
            step();
        end
        chk("refill_full", 32'(full), 32'd1);
        wr_data = 32'hAAAA;
        rd_en   = 1'b1;
        step();
        chk("fullboth_data", rd_data, 32'h300);
        chk("fullboth_valid", 32'(rd_valid), 32'd1);
        chk("fullboth_count", 32'(count), 32'd16);
        chk("fullboth_full", 32'(full), 32'd1);
        chk("fullboth_wr_err", 32'(wr_err), 32'd0);
        $display("full push+pop out=0x%0h count=%0d", rd_data, count);
        wr_en = 1'b0;
        for (int i = 1; i < 17; i++) begin
            step();
            chk("fulldrain_data", rd_data, (i == 16) ? 32'hAAAA : 32'h300 + 32'(i));
            $display("pop 0x%0h count=%0d", rd_data, count);
        end
        chk("fulldrain_empty", 32'(empty), 32'd1);

        // Empty plus simultaneous push and pop
        wr_en   = 1'b1;
        wr_data = 32'h55;
        step();
        chk("emptyboth_rd_err", 32'(rd_err), 32'd1);
        chk("emptyboth_valid", 32'(rd_valid), 32'd0);
        chk("emptyboth_count", 32'(count), 32'd1);
        $display("empty push+pop rd_err=%0d count=%0d", rd_err, count);
        wr_en = 1'b0;
        step();
        chk("emptyboth_pop", rd_data, 32'h55);
        chk("emptyboth_pop_valid", 32'(rd_valid), 32'd1);
        chk("emptyboth_pop_count", 32'(count), 32'd0);
        rd_en = 1'b0;

        // Mid-stream asynchronous reset
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h400 + 32'(i);
            step();
        end
        chk("pre_rst_count", 32'(count), 32'd5);
        rd_en = 1'b1;
        step();
        chk("pre_rst_rdata", rd_data, 32'h400);
        rd_en = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        check_reset_values("async_rst");
        $display("async reset asserted count=%0d", count);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        nrst  = 1'b1;
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);
        rd_en = 1'b1;
        step();
        chk("post_rst_rd_err", 32'(rd_err), 32'd1);
        chk("post_rst_valid", 32'(rd_valid), 32'd0);
        $display("pop after reset rd_err=%0d", rd_err);
        rd_en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
